// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//   Hunts the uart_rx byte stream for HEADER, collects PAYLOAD_BYTES payload
//   bytes, checks an 8-bit additive checksum and splits the payload into
//   en / state_sel / NUM_FIELDS data fields.  A good frame is presented through
//   a valid/ready holding register.  Error pulses feed a saturating counter.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_done, rx_byte     byte strobe and data from uart_rx
//   frame_ready          downstream accepts the held frame
//   frame_valid          held frame valid until accepted
//   en, state_sel        control bits of the held frame
//   data_flat            field i zero-extended at [FIELD_MAX*i +: FIELD_MAX]
//   cksum_err            one-cycle pulse, checksum mismatch
//   timeout_err          one-cycle pulse, inter-byte gap too long inside a frame
//   drop                 one-cycle pulse, good frame lost because slot was full
//   err_cnt              saturating count of the three error pulses
// -----------------------------------------------------------------------------
module uart_frame_parser #(
    parameter logic [7:0]              HEADER        = 8'hA5,
    parameter int                      PAYLOAD_BYTES = 6,
    parameter int                      NUM_FIELDS    = 5,
    parameter int                      FIELD_MAX     = 12,
    parameter logic [5*NUM_FIELDS-1:0] FIELD_WIDTHS  = {5'd12, 5'd7, 5'd6, 5'd8, 5'd8},
    parameter int                      TIMEOUT_CYC   = 50000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rx_done,
    input  logic [7:0]                      rx_byte,
    input  logic                            frame_ready,
    output logic                            frame_valid,
    output logic                            en,
    output logic [3:0]                      state_sel,
    output logic [NUM_FIELDS*FIELD_MAX-1:0] data_flat,
    output logic                            cksum_err,
    output logic                            timeout_err,
    output logic                            drop,
    output logic [7:0]                      err_cnt
);

    localparam int PW = 8 * PAYLOAD_BYTES;
    localparam int CW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    function automatic int fw(input int i);
        return int'(FIELD_WIDTHS[5*i +: 5]);
    endfunction

    // Sum of widths of fields i..NUM_FIELDS-1, i.e. the LSB offset of field i-1.
    function automatic int fsum_from(input int i);
        int s;
        s = 0;
        for (int j = i; j < NUM_FIELDS; j++) s += fw(j);
        return s;
    endfunction

    localparam int S    = fsum_from(0);
    localparam int USED = S + 5;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    state_t                            r_state, w_state_nxt;
    logic [PW-1:0]                     r_shift;
    logic [7:0]                        r_sum;
    logic [CW-1:0]                     r_cnt;
    logic [TW-1:0]                     r_to;
    logic                              r_valid, r_en;
    logic [3:0]                        r_state_sel;
    logic [NUM_FIELDS*FIELD_MAX-1:0]   r_data;
    logic                              r_cksum_err, r_timeout_err, r_drop;
    logic [7:0]                        r_err_cnt;

    logic                              w_good, w_bad, w_to_hit, w_drop;
    logic                              w_to_lim;
    logic [NUM_FIELDS*FIELD_MAX-1:0]   w_data;

    // Limit hit on this cycle unless a byte arrives, in which case the byte wins.
    assign w_to_lim = (r_to == TW'(TIMEOUT_CYC - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        w_to_hit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_done && rx_byte == HEADER) w_state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (rx_done) begin
                    if (r_cnt == CW'(PAYLOAD_BYTES - 1)) w_state_nxt = CHECK;
                end else if (w_to_lim) begin
                    w_to_hit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            CHECK: begin
                if (rx_done) begin
                    w_state_nxt = IDLE;
                    if (rx_byte == r_sum) w_good = 1'b1;
                    else                  w_bad  = 1'b1;
                end else if (w_to_lim) begin
                    w_to_hit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Good frame arriving while the slot is still owned downstream.
    assign w_drop = w_good && r_valid && !frame_ready;

    // ---------------- payload collection ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_to    <= '0;
        end else begin
            if (r_state == IDLE && rx_done && rx_byte == HEADER) begin
                r_sum <= '0;
                r_cnt <= '0;
            end else if (r_state == PAYLOAD && rx_done) begin
                r_shift <= PW'({r_shift, rx_byte});
                r_sum   <= r_sum + rx_byte;
                r_cnt   <= r_cnt + 1'b1;
            end
            if (r_state == IDLE || rx_done || w_to_hit) r_to <= '0;
            else                                        r_to <= r_to + 1'b1;
        end
    end

    // ---------------- field split ----------------
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
        localparam int W   = fw(gi);
        localparam int OFF = fsum_from(gi + 1);
        assign w_data[FIELD_MAX*gi +: FIELD_MAX] = FIELD_MAX'(r_shift[OFF +: W]);
    end

    if (USED < PW) begin : g_unused
        logic w_unused_bits;
        assign w_unused_bits = ^r_shift[PW-1:USED];
    end

    // ---------------- output slot and errors ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_en          <= 1'b0;
            r_state_sel   <= '0;
            r_data        <= '0;
            r_cksum_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_drop        <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_cksum_err   <= w_bad;
            r_timeout_err <= w_to_hit;
            r_drop        <= w_drop;
            if (w_good && !w_drop) begin
                // Empty slot, or old frame handed off this same cycle.
                r_valid     <= 1'b1;
                r_en        <= r_shift[S+4];
                r_state_sel <= r_shift[S+3:S];
                r_data      <= w_data;
            end else if (r_valid && frame_ready) begin
                r_valid <= 1'b0;
            end
            if ((w_bad || w_to_hit || w_drop) && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign frame_valid = r_valid;
    assign en          = r_en;
    assign state_sel   = r_state_sel;
    assign data_flat   = r_data;
    assign cksum_err   = r_cksum_err;
    assign timeout_err = r_timeout_err;
    assign drop        = r_drop;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rx_done = 1'b0, frame_ready = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        frame_valid, en, cksum_err, timeout_err, drop;
    logic [3:0]  state_sel;
    logic [59:0] data_flat;
    logic [7:0]  err_cnt;

    int tests = 0, fails = 0, exp_err = 0;

    uart_frame_parser dut (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_byte(rx_byte),
        .frame_ready(frame_ready), .frame_valid(frame_valid), .en(en),
        .state_sel(state_sel), .data_flat(data_flat), .cksum_err(cksum_err),
        .timeout_err(timeout_err), .drop(drop), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: payload as an integer, fields peeled off with shifts/masks.
    function automatic logic [65:0] model(input logic [47:0] p);
        int          w [5] = '{8, 8, 6, 7, 12};
        longint      v;
        int          off;
        logic [59:0] flat;
        logic        e;
        logic [3:0]  s;
        v = longint'(p);
        off = 0;
        for (int i = 0; i < 5; i++) off += w[i];
        e = 1'((v >> (off + 4)) & 1);
        s = 4'((v >> off) & 15);
        flat = '0;
        for (int i = 0; i < 5; i++) begin
            off -= w[i];
            flat[12*i +: 12] = 12'((v >> off) & ((64'd1 << w[i]) - 1));
        end
        return {1'b1, e, s, flat};
    endfunction

    function automatic logic [7:0] cks(input logic [47:0] p);
        int s = 0;
        for (int i = 0; i < 6; i++) s += int'(p[8*i +: 8]);
        return 8'(s % 256);
    endfunction

    function automatic logic [65:0] got();
        return {frame_valid, en, state_sel, data_flat};
    endfunction

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk); rx_byte = b; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Returns on the negedge right after the checksum byte's clock edge.
    task automatic send_frame(input logic [47:0] p, input logic [7:0] ck,
                              input int gap, input bit ready_last);
        send_byte(HDR, gap);
        for (int i = 0; i < 6; i++) send_byte(p[47-8*i -: 8], gap);
        @(negedge clk); rx_byte = ck; rx_done = 1'b1;
        if (ready_last) frame_ready = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        if (ready_last) frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({got(), cksum_err, timeout_err, drop, err_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h want 0", {got(), cksum_err, timeout_err, drop, err_cnt});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [65:0] exp;
        exp = {1'b1, 1'b1, 4'h5, 12'h345, 12'h012, 12'h01E, 12'h06F, 12'h05E};
        frame_ready = 1'b1;
        send_frame(48'h2ABCDEF12345, 8'h1D, 0, 1'b0);
        tests++;
        if (got() !== exp) begin
            fails++; $display("FAIL good_frame: got %h want %h", got(), exp);
        end
        tests++;
        if (model(48'h2ABCDEF12345) !== exp) begin
            fails++; $display("FAIL model_selfcheck: got %h want %h", model(48'h2ABCDEF12345), exp);
        end
        @(negedge clk);
        tests++;
        if (frame_valid !== 1'b0) begin
            fails++; $display("FAIL good_clear: frame_valid %b want 0", frame_valid);
        end
    endtask

    task automatic test_bad_cksum();
        send_frame(48'h2ABCDEF12345, 8'h1C, 0, 1'b0);
        bump_err();
        tests++;
        if ({cksum_err, frame_valid, err_cnt} !== {1'b1, 1'b0, 8'(exp_err)}) begin
            fails++;
            $display("FAIL bad_cksum: ck/valid/cnt %b/%b/%0d want 1/0/%0d", cksum_err, frame_valid, err_cnt, exp_err);
        end
        @(negedge clk);
        tests++;
        if (cksum_err !== 1'b0) begin
            fails++; $display("FAIL cksum_pulse_width: cksum_err %b want 0", cksum_err);
        end
    endtask

    task automatic test_garbage();
        send_byte(8'h00, 0); send_byte(8'hFF, 1); send_byte(8'h13, 0);
        send_frame(48'h2ABCDEF12345, 8'h1D, 0, 1'b0);
        tests++;
        if (got() !== model(48'h2ABCDEF12345)) begin
            fails++; $display("FAIL garbage_header: got %h want %h", got(), model(48'h2ABCDEF12345));
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int k;
        send_byte(HDR, 0); send_byte(8'h2A, 0);
        k = 0;
        while (timeout_err !== 1'b1 && k < 50100) begin
            @(negedge clk); k++;
        end
        bump_err();
        tests++;
        if (k !== 50000 || err_cnt !== 8'(exp_err)) begin
            fails++;
            $display("FAIL timeout: cycles %0d cnt %0d want 50000 cnt %0d", k, err_cnt, exp_err);
        end
        send_frame(48'h2ABCDEF12345, 8'h1D, 0, 1'b0);
        tests++;
        if (got() !== model(48'h2ABCDEF12345)) begin
            fails++; $display("FAIL after_timeout: got %h want %h", got(), model(48'h2ABCDEF12345));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [47:0] p;
        logic [7:0]  ck, b;
        bit          bad;
        int          gap;
        for (int n = 0; n < 20; n++) begin
            p   = {16'($urandom), 32'($urandom)};
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2);
            ck  = cks(p);
            if (bad) ck = ck + 8'($urandom_range(1, 255));
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h00;
                send_byte(b, gap);
            end
            send_frame(p, ck, gap, 1'b0);
            if (bad) bump_err();
            tests++;
            if (bad ? ({cksum_err, frame_valid, err_cnt} !== {1'b1, 1'b0, 8'(exp_err)})
                    : (got() !== model(p) || cksum_err !== 1'b0)) begin
                fails++;
                $display("FAIL random_%0d: got %h ck %b cnt %0d want %h bad %b cnt %0d",
                         n, got(), cksum_err, err_cnt, model(p), bad, exp_err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] pa, pb;
        pa = {16'($urandom), 32'($urandom)};
        pb = {16'($urandom), 32'($urandom)};
        frame_ready = 1'b0;
        send_frame(pa, cks(pa), 0, 1'b0);
        tests++;
        if (got() !== model(pa)) begin
            fails++; $display("FAIL bp_first: got %h want %h", got(), model(pa));
        end
        send_frame(pb, cks(pb), 1, 1'b0);
        bump_err();
        tests++;
        if (got() !== model(pa) || drop !== 1'b1 || err_cnt !== 8'(exp_err)) begin
            fails++;
            $display("FAIL bp_drop: got %h drop %b cnt %0d want %h drop 1 cnt %0d",
                     got(), drop, err_cnt, model(pa), exp_err);
        end
        frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;
        tests++;
        if (frame_valid !== 1'b0) begin
            fails++; $display("FAIL bp_accept: frame_valid %b want 0", frame_valid);
        end
        // Ready raised in the completion cycle: handoff plus reload, no drop.
        send_frame(pa, cks(pa), 0, 1'b0);
        send_frame(pb, cks(pb), 0, 1'b1);
        tests++;
        if (got() !== model(pb) || drop !== 1'b0 || err_cnt !== 8'(exp_err)) begin
            fails++;
            $display("FAIL bp_swap: got %h drop %b cnt %0d want %h drop 0 cnt %0d",
                     got(), drop, err_cnt, model(pb), exp_err);
        end
        @(negedge clk);
        tests++;
        if (got() !== model(pb) || drop !== 1'b0) begin
            fails++; $display("FAIL bp_hold: got %h drop %b want %h drop 0", got(), drop, model(pb));
        end
        frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;
    endtask

    task automatic test_reset_saturation();
        logic [47:0] p;
        frame_ready = 1'b0;
        send_frame(48'h2ABCDEF12345, 8'h1D, 0, 1'b0);
        send_byte(HDR, 0); send_byte(8'h2A, 0); send_byte(8'hBC, 0);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({got(), cksum_err, timeout_err, drop, err_cnt} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got %h want 0", {got(), cksum_err, timeout_err, drop, err_cnt});
        end
        exp_err = 0;
        @(negedge clk); rst_n = 1'b1;
        // Tail of the interrupted frame must not be taken as a frame.
        send_byte(8'hDE, 0); send_byte(8'hF1, 0); send_byte(8'h23, 0);
        send_byte(8'h45, 0); send_byte(8'h1D, 0);
        @(negedge clk);
        tests++;
        if (frame_valid !== 1'b0 || err_cnt !== 8'd0) begin
            fails++; $display("FAIL partial_discard: valid %b cnt %0d want 0 0", frame_valid, err_cnt);
        end
        for (int n = 0; n < 300; n++) begin
            p = {16'($urandom), 32'($urandom)};
            send_frame(p, cks(p) ^ 8'h01, 0, 1'b0);
            bump_err();
            if (n == 9) begin
                tests++;
                if (err_cnt !== 8'd10) begin
                    fails++; $display("FAIL err_cnt_10: got %0d want 10", err_cnt);
                end
            end
        end
        @(negedge clk);
        tests++;
        if (err_cnt !== 8'(exp_err) || exp_err != 255) begin
            fails++; $display("FAIL err_cnt_sat: got %0d want 255", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_cksum();
        test_garbage();
        test_timeout();
        test_random();
        test_backpressure();
        test_reset_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
